orientation_moment_unit: RTL
============================

Name: orientation_moment_unit

Overview:
- Streaming intensity-centroid moment engine for the keypoint orientation stage of the ORB feature pipeline.
- Accepts one (2R+1)-pixel image column per valid beat from the line-buffer window generator and keeps a sliding window of the last 2R+1 columns.
- Emits signed first moments m_x and m_y per window position, with a valid strobe, centre-column index and optional circular patch mask.
- Parametrised successor of the fixed 7x7 orientation block: adds configurable radius and pixel width, stall tolerance, per-line fill tracking and masking.

Parameters:
- RADIUS, 3, patch radius R; patch side N = 2R+1.
- PIX_W, 8, unsigned pixel width.
- WIDTH, 640, columns per image line.
- OUT_W, 16, signed moment width. Elaboration error if OUT_W < clog2((2^PIX_W-1)*N*R*(R+1)) + 1.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_valid  in  1  i_col carries a new column this cycle.
- i_sol  in  1  start of line; qualified by i_valid.
- i_mask_en  in  1  1 = circular mask, 0 = full square; sampled with each valid beat.
- i_col  in  N*PIX_W  i_col[k*PIX_W +: PIX_W] = patch row k, with dy = R-k (row 0 on top, dy = +R).
- o_valid  out  1  one-cycle strobe, new moments present.
- o_mx  out  OUT_W  signed sum of dx*p over the window.
- o_my  out  OUT_W  signed sum of dy*p over the window.
- o_col  out  clog2(WIDTH)  line column index of the window centre.

Behaviour:
- Window:
  - Shift register of N columns; the newest column has dx = +R, the oldest dx = -R.
  - Shifts only on i_valid. With i_valid low, window, counters and outputs hold.
- Moments:
  - m_x = sum over dx,dy of dx*p(dx,dy)*w(dx,dy); m_y is the same with dy as the weight.
  - w = 1 for every pixel when the mask is off.
  - With the mask on, w = 1 iff dx^2+dy^2 <= R^2, else 0. The mask is constant, computed at elaboration.
  - Products are exact, with no truncation or saturation; the OUT_W check guarantees no overflow.
- Line tracking:
  - col_cnt: column index of the current beat. Set to 0 on a beat with i_sol=1, otherwise incremented per beat.
  - col_cnt wraps from WIDTH-1 to 0; the wrap is treated exactly as an i_sol beat.
  - fill: set to 1 on an sol/wrap beat, otherwise incremented per beat, saturating at N.
  - A window is qualifying when fill == N after the beat.
- Timing:
  - o_valid pulses exactly 2 cycles after each qualifying beat (stage 1: per-position column reduce; stage 2: weighted combine).
  - The pipeline always advances, so gaps in i_valid do not add latency.
  - o_col = col_cnt - R of the qualifying beat.
  - o_mx, o_my and o_col hold their last value when o_valid = 0.
- Line boundaries:
  - Beats 0..N-2 after sol never assert o_valid.
  - Columns from the previous line never mix into a new-line window: fill gates validity, and the stale shift-register contents are ignored.
- i_mask_en is latched with the beat, so results in flight use the mask of their own beat.
- Reset, including mid-line:
  - o_valid = 0, o_mx = 0, o_my = 0, o_col = 0; fill, col_cnt and the window are cleared.
  - In-flight results are discarded.
  - The first beat after reset is treated as sol regardless of i_sol.

Decomposition:
- Package orientation_pkg holds:
  - the clog2 function;
  - the moment-width function used by the OUT_W check;
  - the mask function mask_w(R, dx, dy) returning 0 or 1.
- Sub-module orient_col_reduce, parametrised by RADIUS, PIX_W and DX. Given one column and the mask enable, it registers:
  - S = masked sum of p;
  - Y = masked sum of dy*p.
- The top instantiates N of them, one per window position, then combines the results into o_mx and o_my.

Test Plan:
- R=3, mask off: sol, then 7 beats with all pixels 1 -> single o_valid 2 cycles after beat 7; o_mx=0, o_my=0, o_col=3. No o_valid during beats 1-6.
- R=3, mask off: 7th (newest) column all 10, others 0 -> o_mx=210, o_my=0. The following beat of zeros -> o_mx=140.
- R=3: row 0 of all columns = 100, other rows 0 -> mask off o_my=2100, o_mx=0; mask on o_my=300.
- R=3, PIX_W=8, mask off: newest 3 columns 255, rest 0 -> o_mx=10710 (within 16 bits); mirrored case -> o_mx=-10710.
- Stall: 7 beats with random 1-5 cycle i_valid gaps -> o_valid count and values match the gap-free run; outputs stable during gaps.
- Boundaries:
  - i_sol at col 4 -> no o_valid until 7 beats later, o_col restarts at 3.
  - WIDTH+1 beats without sol -> wrap behaves as sol.
  - i_rst_n low mid-line for 1 cycle -> all outputs 0, pending o_valid suppressed.

Source files
------------

// File: rtl/orientation_pkg.sv
// orientation_pkg: width helpers and circular patch mask shared by the moment engine
package orientation_pkg;
   function automatic int clog2(input longint v);
      int n;
      n = 0;
      for (int i = 0; i < 62; i++) if ((longint'(1) << i) < v) n = i + 1;
      return n;
   endfunction
   function automatic int moment_w(input int r, input int pix_w);
      return clog2(((longint'(1) << pix_w) - 1) * longint'(2 * r + 1) * r * (r + 1)) + 1;
   endfunction
   function automatic int mask_w(input int r, input int dx, input int dy);
      return (dx * dx + dy * dy <= r * r) ? 1 : 0;
   endfunction
endpackage

// File: rtl/orient_col_reduce.sv
// orient_col_reduce: registered masked pixel sum and dy-weighted sum of one window column at offset DX
module orient_col_reduce import orientation_pkg::*; #(
   parameter int RADIUS = 3,
   parameter int PIX_W = 8,
   parameter int DX = 0,
   localparam int N = 2 * RADIUS + 1,
   localparam int SW = moment_w(RADIUS, PIX_W)
) (
   input logic clk,
   input logic rst_n,
   input logic [N*PIX_W-1:0] col,
   input logic mask_en,
   output logic signed [SW-1:0] s,
   output logic signed [SW-1:0] y
);
   logic signed [SW-1:0] s_c, y_c, p;
   always_comb begin
      s_c = '0;
      y_c = '0;
      p = '0;
      for (int k = 0; k < N; k++) begin
         p = SW'(col[k*PIX_W +: PIX_W]);
         if (!mask_en || mask_w(RADIUS, DX, RADIUS - k) == 1) begin
            s_c = s_c + p;
            y_c = y_c + p * SW'(RADIUS - k);
         end
      end
   end
   always_ff @(posedge clk)
      if (!rst_n) begin
         s <= '0;
         y <= '0;
      end else begin
         s <= s_c;
         y <= y_c;
      end
endmodule

// File: rtl/orientation_moment_unit.sv
// orientation_moment_unit: streaming intensity-centroid first moments over a sliding (2R+1)^2 patch
module orientation_moment_unit import orientation_pkg::*; #(
   parameter int RADIUS = 3,
   parameter int PIX_W = 8,
   parameter int WIDTH = 640,
   parameter int OUT_W = 16,
   localparam int N = 2 * RADIUS + 1,
   localparam int CW = clog2(WIDTH)
) (
   input logic i_clk,
   input logic i_rst_n,
   input logic i_valid,
   input logic i_sol,
   input logic i_mask_en,
   input logic [N*PIX_W-1:0] i_col,
   output logic o_valid,
   output logic signed [OUT_W-1:0] o_mx,
   output logic signed [OUT_W-1:0] o_my,
   output logic [CW-1:0] o_col
);
   localparam int SW = moment_w(RADIUS, PIX_W);
   localparam int FW = clog2(N + 1);
   if (OUT_W < SW) begin : g_width_check
      $error("orientation_moment_unit: OUT_W too narrow for RADIUS/PIX_W");
   end
   logic [N*PIX_W-1:0] win [N];
   logic first, mask_r, q0, q1, sol;
   logic [CW-1:0] col_cnt, cnt_n, col0, col1;
   logic [FW-1:0] fill, fill_n;
   logic signed [SW-1:0] s [N];
   logic signed [SW-1:0] y [N];
   logic signed [OUT_W-1:0] mx_c, my_c;
   // a wrap or the first beat after reset starts a line exactly like i_sol
   always_comb begin
      sol = i_sol || first || col_cnt == CW'(WIDTH - 1);
      cnt_n = sol ? '0 : col_cnt + CW'(1);
      fill_n = sol ? FW'(1) : fill == FW'(N) ? fill : fill + FW'(1);
   end
   always_ff @(posedge i_clk)
      if (!i_rst_n) begin
         first <= 1'b1;
         col_cnt <= '0;
         fill <= '0;
         mask_r <= 1'b0;
         q0 <= 1'b0;
         col0 <= '0;
         for (int j = 0; j < N; j++) win[j] <= '0;
      end else if (i_valid) begin
         first <= 1'b0;
         col_cnt <= cnt_n;
         fill <= fill_n;
         mask_r <= i_mask_en;
         q0 <= fill_n == FW'(N);
         col0 <= cnt_n - CW'(RADIUS);
         for (int j = 0; j < N - 1; j++) win[j] <= win[j+1];
         win[N-1] <= i_col;
      end else begin
         q0 <= 1'b0;
      end
   for (genvar g = 0; g < N; g++) begin : g_pos
      orient_col_reduce #(.RADIUS(RADIUS), .PIX_W(PIX_W), .DX(g - RADIUS)) u_reduce (
         .clk(i_clk),
         .rst_n(i_rst_n),
         .col(win[g]),
         .mask_en(mask_r),
         .s(s[g]),
         .y(y[g])
      );
   end
   always_comb begin
      mx_c = '0;
      my_c = '0;
      for (int j = 0; j < N; j++) begin
         mx_c = mx_c + OUT_W'(s[j]) * OUT_W'(j - RADIUS);
         my_c = my_c + OUT_W'(y[j]);
      end
   end
   always_ff @(posedge i_clk)
      if (!i_rst_n) begin
         q1 <= 1'b0;
         col1 <= '0;
         o_valid <= 1'b0;
         o_mx <= '0;
         o_my <= '0;
         o_col <= '0;
      end else begin
         q1 <= q0;
         col1 <= col0;
         o_valid <= q1;
         if (q1) begin
            o_mx <= mx_c;
            o_my <= my_c;
            o_col <= col1;
         end
      end
endmodule
